// File: rtl/ttl_74194_pkg.sv
// Shared mode encodings for the 74194-style universal shift register and
// any sibling register blocks that want identical Select values.
package ttl_74194_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD        = 2'b00,
    MODE_SHIFT_RIGHT = 2'b01,
    MODE_SHIFT_LEFT  = 2'b10,
    MODE_LOAD        = 2'b11
  } mode_e;

endpackage

// File: rtl/ttl_74194_if.sv
// Data/control bundle for a 74194 register: the master drives mode, serial
// and parallel data, and the slave returns the register contents.
interface ttl_74194_if #(
  parameter int unsigned WIDTH = 4
);
  logic [1:0]       select;
  logic             dsr;
  logic             dsl;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output select, output dsr, output dsl, output d, input q);
  modport slave  (input select, input dsr, input dsl, input d, output q);
endinterface

// File: rtl/ttl_74194_cell.sv
// One register stage: 4:1 next-state select (hold, shift-right source,
// shift-left source, parallel D) feeding a flop with synchronous clear.
module ttl_74194_cell
  import ttl_74194_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] select,
  input  logic       shr_in,
  input  logic       shl_in,
  input  logic       d,
  output logic       q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 1'b0;
    end else begin
      case (select)
        MODE_HOLD:        q <= q;
        MODE_SHIFT_RIGHT: q <= shr_in;
        MODE_SHIFT_LEFT:  q <= shl_in;
        MODE_LOAD:        q <= d;
        // An unknown mode leaves the stage unknown rather than guessing.
        default:          q <= 1'bx;
      endcase
    end
  end

endmodule

// File: rtl/ttl_74194.sv
// 74194-style universal shift register: hold, shift right, shift left and
// parallel load, synchronous clear, with rise/fall delays only on Q.
module ttl_74194 #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DELAY_RISE = 0,
  parameter int unsigned DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic [1:0]       Select,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] shr_src;
  logic [WIDTH-1:0] shl_src;

  // Per-stage neighbour taps; the end stages take the serial inputs instead.
  assign shr_src = {state[WIDTH-2:0], DSR};
  assign shl_src = {DSL, state[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ttl_74194_cell u_cell (
      .clk    (Clk),
      .clear  (Clear),
      .select (Select),
      .shr_in (shr_src[i]),
      .shl_in (shl_src[i]),
      .d      (D[i]),
      .q      (state[i])
    );
  end

  assign #(DELAY_RISE, DELAY_FALL) Q = state;

endmodule
